mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 The clock input is clock; the reset input is clear; there is one clock; clear is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 clear  in  1  synchronous active-high reset.
REQ-006 i_req  in  1  instruction-fetch read request; held until i_ack.
REQ-007 i_addr  in  ADDR_W  fetch word address; stable while i_req.
REQ-008 i_rdata  out  DATA_W  fetch read data.
REQ-009 i_ack  out  1  one-cycle fetch completion strobe.
REQ-010 d_req  in  1  data request; held until d_ack.
REQ-011 d_we  in  1  1 = write, 0 = read; stable while d_req.
REQ-012 d_addr  in  ADDR_W  data word address.
REQ-013 d_wdata  in  DATA_W  write data.
REQ-014 d_rdata  out  DATA_W  data read data.
REQ-015 d_ack  out  1  one-cycle data completion strobe.
REQ-016 mem_addr  out  ADDR_W  registered address to the single-port synchronous RAM.
REQ-017 mem_din  out  DATA_W  registered write data to the RAM.
REQ-018 mem_wren  out  1  registered RAM write enable.
REQ-019 mem_dout  in  DATA_W  RAM read data, valid one edge after the address is sampled.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-022 IDLE: on an edge with any request high, the FSM SHALL register the winner, mem_addr and mem_din, set mem_wren = d_we only if D wins, and move to ACCESS; with no request it SHALL stay in IDLE.
REQ-023 ACCESS: the RAM samples on the edge that leaves ACCESS; on that edge the FSM SHALL clear mem_wren, set the winner's ack register, and move to RESP.
REQ-024 RESP: the winner's ack SHALL be 1 for exactly this cycle, and its rdata SHALL equal mem_dout combinationally.
REQ-025 On the edge leaving RESP, the block SHALL capture mem_dout into the winner's rdata holding register, clear ack, and move to IDLE.
REQ-026 Outside RESP, each rdata output SHALL hold its last captured value; the non-winning requester's rdata SHALL be unchanged.
REQ-027 Latency: a request sampled at edge E0 SHALL produce ack high in the cycle between E1 and E2; throughput SHALL be 1 access per 3 cycles.
REQ-028 Requests SHALL be sampled only in IDLE; a request that rises during ACCESS or RESP SHALL wait.
REQ-029 A requester drops req on the edge where it sees ack; the arbiter SHALL therefore never re-grant a completed access.
REQ-030 Arbitration: if only one request is high, that requester SHALL win.
REQ-031 If both requests are high, the requester not granted most recently SHALL win (round-robin); last_grant SHALL update on every grant.
REQ-032 last_grant SHALL reset to I, so the first tie goes to D.
REQ-033 On a write, d_ack SHALL still pulse; d_rdata SHALL take the RAM's read-during-write output.
REQ-034 The two ack outputs SHALL never be high in the same cycle, and neither SHALL be high outside RESP.
REQ-035 mem_wren SHALL be high only in ACCESS, and only for a D write.

Reset
REQ-036 While clear = 1 at an edge, the block SHALL set: state = IDLE, last_grant = I, mem_wren = 0, mem_addr = 0, mem_din = 0, i_ack = d_ack = 0, i_rdata = d_rdata = 0, busy = 0.
REQ-037 clear in ACCESS or RESP SHALL abort the access with no ack.
REQ-038 An aborted write whose ACCESS-exit edge coincides with clear SHALL still commit, because mem_wren was already high at that edge.
REQ-039 The first request SHALL be sampled on the first edge after clear deasserts.

Verification
REQ-040 After clear, i_req = 1, i_addr = 0x05, RAM[5] = 0x00000013 -> i_ack in the 2nd cycle after the sampling edge, i_rdata = 0x00000013, busy high for 2 cycles.
REQ-041 d_req = 1, d_we = 1, d_addr = 0xFF, d_wdata = 0x41, then a read of 0xFF -> mem_wren high for exactly 1 cycle; the read returns 0x00000041.
REQ-042 i_req and d_req held high from reset -> grant order D, I, D, I; acks alternate every 3 cycles; the two acks are never simultaneous.
REQ-043 clear asserted during ACCESS of a D read -> no d_ack, state = IDLE, all outputs at reset values on the next cycle.
REQ-044 d_req rises while a fetch is in RESP -> the fetch completes undisturbed, and the D grant occurs on the next IDLE edge.
REQ-045 Back-to-back fetches to addresses 0..15 -> i_rdata matches RAM contents in order, 16 acks in 48 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and data) in front of a single-port synchronous RAM.
// Each grant runs IDLE -> ACCESS -> RESP; ties are broken round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic              lastGrantD;
    logic              lastGrantDNext;
    logic              winnerD;
    logic              winnerDNext;
    logic              grantD;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memDinNext;
    logic              memWrenNext;
    logic              iAckNext;
    logic              dAckNext;
    logic [DATA_W-1:0] iHold;
    logic [DATA_W-1:0] iHoldNext;
    logic [DATA_W-1:0] dHold;
    logic [DATA_W-1:0] dHoldNext;

    // D wins when alone, or on a tie when I was granted last.
    assign grantD = d_req && (!i_req || !lastGrantD);

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= IDLE;
            lastGrantD <= 1'b0;
            winnerD    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_wren   <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            iHold      <= '0;
            dHold      <= '0;
        end else begin
            state      <= stateNext;
            lastGrantD <= lastGrantDNext;
            winnerD    <= winnerDNext;
            mem_addr   <= memAddrNext;
            mem_din    <= memDinNext;
            mem_wren   <= memWrenNext;
            i_ack      <= iAckNext;
            d_ack      <= dAckNext;
            iHold      <= iHoldNext;
            dHold      <= dHoldNext;
        end
    end

    always_comb begin
        stateNext      = state;
        lastGrantDNext = lastGrantD;
        winnerDNext    = winnerD;
        memAddrNext    = mem_addr;
        memDinNext     = mem_din;
        memWrenNext    = 1'b0;
        iAckNext       = 1'b0;
        dAckNext       = 1'b0;
        iHoldNext      = iHold;
        dHoldNext      = dHold;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    winnerDNext    = grantD;
                    lastGrantDNext = grantD;
                    memAddrNext    = grantD ? d_addr : i_addr;
                    memDinNext     = d_wdata;
                    memWrenNext    = grantD && d_we;
                    stateNext      = ACCESS;
                end
            end
            ACCESS: begin
                iAckNext  = !winnerD;
                dAckNext  = winnerD;
                stateNext = RESP;
            end
            RESP: begin
                if (winnerD) begin
                    dHoldNext = mem_dout;
                end else begin
                    iHoldNext = mem_dout;
                end
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // RAM data passes straight through to the winner during RESP.
    assign i_rdata = (state == RESP && !winnerD) ? mem_dout : iHold;
    assign d_rdata = (state == RESP &&  winnerD) ? mem_dout : dHold;
    assign busy    = (state != IDLE);

endmodule
